// File: rtl/mux2x1_arbiter.sv
// Two-input stream merge with round-robin arbitration into a one-entry registered output tagged with its source (Es: 0=A, 1=B).
// Define MUX2X1_PRIORITY_A_EN for fixed A-over-B priority on ties instead of round-robin.
module mux2x1_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic             A_valid,
  output logic             A_ready,
  input  logic [WIDTH-1:0] B,
  input  logic             B_valid,
  output logic             B_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Es,
  output logic             Y_valid,
  input  logic             Y_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             es_q, es_d;
  logic             can_load;
  logic             grant_vld;
  logic             grant_sel;
  logic             accept;

`ifndef MUX2X1_PRIORITY_A_EN
  logic             last_sel_q, last_sel_d;
`endif

  always_comb begin
    can_load  = (state_q == EMPTY) || Y_ready;
    grant_vld = A_valid || B_valid;
`ifdef MUX2X1_PRIORITY_A_EN
    grant_sel = !A_valid;
`else
    // On a tie, serve the channel that did not win the last accepted beat.
    grant_sel = (A_valid && B_valid) ? !last_sel_q : !A_valid;
`endif
    accept  = !rst && can_load && grant_vld;
    A_ready = accept && !grant_sel;
    B_ready = accept && grant_sel;
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    es_d    = es_q;
`ifndef MUX2X1_PRIORITY_A_EN
    last_sel_d = last_sel_q;
`endif
    if (accept) begin
      state_d = FULL;
      y_d     = grant_sel ? B : A;
      es_d    = grant_sel;
`ifndef MUX2X1_PRIORITY_A_EN
      last_sel_d = grant_sel;
`endif
    end else if (Y_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      es_q    <= 1'b0;
`ifndef MUX2X1_PRIORITY_A_EN
      last_sel_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      es_q    <= es_d;
`ifndef MUX2X1_PRIORITY_A_EN
      last_sel_q <= last_sel_d;
`endif
    end
  end

  assign Y       = y_q;
  assign Es      = es_q;
  assign Y_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Bench for mux2x1_arbiter: each cycle carries its expected readies; accepted beats queue up and are matched against Y/Es.
module tb_mux2x1_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] A = 8'h00;
  logic       A_valid = 1'b1;
  logic       A_ready;
  logic [7:0] B = 8'h00;
  logic       B_valid = 1'b1;
  logic       B_ready;
  logic [7:0] Y;
  logic       Es;
  logic       Y_valid;
  logic       Y_ready = 1'b1;

  always #5 clk = ~clk;

  mux2x1_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .A(A), .A_valid(A_valid), .A_ready(A_ready),
    .B(B), .B_valid(B_valid), .B_ready(B_ready),
    .Y(Y), .Es(Es), .Y_valid(Y_valid), .Y_ready(Y_ready)
  );

  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] a;
    logic       bv;
    logic [7:0] b;
    logic       yr;
    logic       ea;
    logic       eb;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       es;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  last_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic av, input logic [7:0] a,
                              input logic bv, input logic [7:0] b, input logic yr,
                              input logic ea, input logic eb);
    vec_t v;
    v.rst = r; v.av = av; v.a = a; v.bv = bv; v.b = b; v.yr = yr; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic cycle(input vec_t v);
    beat_t bt;
    @(posedge clk);
    #1;
    rst = v.rst; A_valid = v.av; A = v.a; B_valid = v.bv; B = v.b; Y_ready = v.yr;
    @(negedge clk);
    check("A_ready", {31'd0, A_ready}, {31'd0, v.ea});
    check("B_ready", {31'd0, B_ready}, {31'd0, v.eb});
    check("Y_valid", {31'd0, Y_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("Y", {24'd0, Y}, {24'd0, exp_q[0].d});
      check("Es", {31'd0, Es}, {31'd0, exp_q[0].es});
    end
    if (last_rst) begin
      check("Y_after_rst", {24'd0, Y}, 32'd0);
      check("Es_after_rst", {31'd0, Es}, 32'd0);
    end
    last_rst = v.rst;
    if (v.rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && v.yr) void'(exp_q.pop_front());
      if (v.ea) begin bt.d = v.a; bt.es = 1'b0; exp_q.push_back(bt); end
      if (v.eb) begin bt.d = v.b; bt.es = 1'b1; exp_q.push_back(bt); end
    end
  endtask

  task automatic step(input logic r, input logic av, input logic [7:0] a,
                      input logic bv, input logic [7:0] b, input logic yr,
                      input logic ea, input logic eb);
    cycle(mk(r, av, a, bv, b, yr, ea, eb));
  endtask

  vec_t tbl[7];

  initial begin
    // Reset with both valid, first tie to A, then single-channel beats.
    tbl[0] = mk(1, 1, 8'h01, 1, 8'h02, 1, 0, 0);
    tbl[1] = mk(1, 1, 8'h01, 1, 8'h02, 1, 0, 0);
    tbl[2] = mk(0, 1, 8'h01, 1, 8'h02, 1, 1, 0);
    tbl[3] = mk(0, 1, 8'h3C, 0, 8'h00, 1, 1, 0);
    tbl[4] = mk(0, 0, 8'h00, 1, 8'hA5, 1, 0, 1);
    tbl[5] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    tbl[6] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 7; i++) cycle(tbl[i]);

    // Sustained contention: the first tie after a B win goes to A.
    begin
      int ai = 0;
      int bi = 0;
      for (int i = 0; i < 6; i++) begin
        logic ea;
`ifdef MUX2X1_PRIORITY_A_EN
        ea = 1'b1;
`else
        ea = (i % 2 == 0);
`endif
        step(0, 1, 8'h10 + 8'(ai), 1, 8'h20 + 8'(bi), 1, ea, !ea);
        if (ea) ai++; else bi++;
      end
    end
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);

`ifdef MUX2X1_PRIORITY_A_EN
    for (int i = 0; i < 4; i++) step(0, 1, 8'h60 + 8'(i), 1, 8'h70, 1, 1, 0);
    step(0, 0, 8'h00, 1, 8'h70, 1, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
`else
    // Priority rotates only on accepted beats, never on idle or stall cycles.
    step(0, 1, 8'h31, 1, 8'h41, 1, 1, 0);
    step(0, 1, 8'h32, 1, 8'h41, 1, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 1, 8'h32, 1, 8'h42, 1, 1, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
`endif

    // Backpressure: 55 held through a 5-cycle stall, then B follows with no gap.
    step(0, 1, 8'h55, 0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 8'h66, 0, 0, 0);
    step(0, 0, 8'h00, 1, 8'h66, 1, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);

    // Reset while FULL discards the beat; next tie goes to A.
    step(0, 1, 8'h77, 0, 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    step(1, 1, 8'h78, 1, 8'h88, 0, 0, 0);
    step(0, 1, 8'h78, 1, 8'h88, 1, 1, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);

    check("drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux2x1_arbiter.md
# mux2x1_arbiter

Two-input, one-output stream multiplexer with valid/ready handshakes and a registered output. It merges the two channels that a 1-to-2 demultiplexer feeds back into a single stream. Contention is resolved by round-robin arbitration. The output carries a select tag `Es` recording which input produced each beat, so a downstream `demux1x2` can route data back using the same select convention: `Es=0` means A, `Es=1` means B.

## Interface
- `WIDTH`, default 8: data width of A, B and Y.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `A` input WIDTH: channel A data.
- `A_valid` input 1: channel A data is valid.
- `A_ready` output 1: channel A beat accepted this cycle when `A_valid && A_ready`.
- `B` input WIDTH: channel B data.
- `B_valid` input 1: channel B data is valid.
- `B_ready` output 1: channel B beat accepted this cycle when `B_valid && B_ready`.
- `Y` output WIDTH: registered output data.
- `Es` output 1: registered source tag for `Y` (0 = A, 1 = B).
- `Y_valid` output 1: `Y`/`Es` hold a beat.
- `Y_ready` input 1: downstream accepts `Y` when `Y_valid && Y_ready`.

## Operation
- One-entry output register, with two states:
  - **EMPTY**: `Y_valid=0`.
  - **FULL**: `Y_valid=1`.
- `can_load = !Y_valid || Y_ready`. The register is free now or drained this same cycle.
- Grant, evaluated combinationally each cycle:
  - Only `A_valid` → grant A.
  - Only `B_valid` → grant B.
  - Both valid → grant the channel opposite `last_sel`.
  - Neither valid → no grant.
- `A_ready = !rst && can_load && grant==A`. `B_ready = !rst && can_load && grant==B`. At most one ready is high in any cycle.
- On an accepted beat:
  - `Y` ← granted data.
  - `Es` ← granted index.
  - `Y_valid` ← 1.
  - `last_sel` ← granted index.
- State transitions:
  - EMPTY→FULL on an accept.
  - FULL→EMPTY when `Y_ready` is high and no new accept.
  - FULL→FULL when `Y_ready` is high with an accept (back-to-back), or when `Y_ready` is low (hold).
- While FULL and `Y_ready=0`: `Y`, `Es` and `Y_valid` are stable, and both readies are 0.
- `last_sel` updates only on accepted beats. Idle cycles and stalls do not rotate priority.
- Input data is never dropped or duplicated. Per-channel order is preserved.

## Timing
- Reset values (registered, at the first edge with `rst=1`): `Y=0`, `Es=0`, `Y_valid=0`, `last_sel=1`. With `last_sel=1`, the first tie goes to A.
- While `rst=1`, `A_ready=B_ready=0` combinationally.
- Reset during FULL discards the held beat. `Y_valid` is 0 after that edge.
- Latency: a beat accepted at edge N appears on `Y` with `Y_valid=1` after edge N.
- Throughput: 1 beat/cycle when `Y_ready` is held high.
- Under sustained contention, grants strictly alternate A, B, A, B…
- Readies depend combinationally on `*_valid`, `Y_ready` and state. There is no combinational path from `A`/`B` data to any output.

## Configuration
- `MUX2X1_PRIORITY_A_EN`:
  - **Defined:** fixed priority. On a tie, A always wins. `last_sel` is not implemented. Channel B can starve under continuous A traffic.
  - **Undefined (default):** round-robin arbitration as described above.

## Test plan
- **Reset:** `rst=1` for 2 cycles with `A_valid=B_valid=1` → `Y_valid=0`, `Y=0`, `Es=0`, `A_ready=B_ready=0`. After release, the first grant is A.
- **Single channel:**
  - `A=8'h3C` valid for 1 cycle, `Y_ready=1` → next cycle `Y=8'h3C`, `Es=0`, `Y_valid=1`.
  - Same with `B=8'hA5` → `Y=8'hA5`, `Es=1`.
- **Contention:** A streams 8'h10, 8'h11, 8'h12…; B streams 8'h20, 8'h21…; both always valid; `Y_ready=1` → Y sequence is 10/0, 20/1, 11/0, 21/1, 12/0, 22/1 (data/Es).
- **Backpressure:** load 8'h55 from A, then hold `Y_ready=0` for 5 cycles with B valid → `Y=8'h55`, `Es=0` stable, `B_ready=0`. Raise `Y_ready` → the B beat appears the next cycle with `Es=1`, no gap.
- **Mid-operation reset:** FULL with `Y=8'h77`, assert `rst` for 1 cycle → `Y_valid=0`, `Y=0`. Restart with a tie → A granted first.
- **`MUX2X1_PRIORITY_A_EN` defined:** both channels continuously valid for 4 beats → all 4 outputs have `Es=0`, `B_ready` never high. Drop `A_valid` → the B beat is accepted that cycle.
